// File: rtl/mult_sequencer_pkg.sv
// mult_sequencer_pkg: shared widths, constants and FSM state type for the sequential multiplier
package mult_sequencer_pkg;
  localparam int DW_DEFAULT = 8;
  localparam int DW_2_DEFAULT = 2 * DW_DEFAULT;
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
  localparam int CNT_W = cnt_width(DW_DEFAULT);
  localparam int ONE = 1;
  localparam int ZERO = 0;
  localparam logic BIT_ONE = 1'b1;
  typedef enum logic [2:0] {IDLE, LOAD, MULT, FIX, DONE} state_t;
endpackage

// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if: start/ready request plus result bus of the multiplier
// master drives start/multiplicand/multiplier; slave drives ready/busy/done/sign/result
interface mult_sequencer_if import mult_sequencer_pkg::*; #(parameter int DW = DW_DEFAULT);
  logic start;
  logic [DW-1:0] multiplicand;
  logic [DW-1:0] multiplier;
  logic ready;
  logic busy;
  logic done;
  logic sign;
  logic [2*DW-1:0] result;
  modport master(output start, multiplicand, multiplier, input ready, busy, done, sign, result);
  modport slave(input start, multiplicand, multiplier, output ready, busy, done, sign, result);
endinterface

// File: rtl/mult_sequencer_datapath.sv
// mult_datapath: operand magnitudes, shift-add accumulator, iteration count and sign fix
// ports: clk, rst (async high), load/step/fix strobes, a/b operands, count_last, sign, result
// SIGNED_MODE_EN selects two's-complement operands; otherwise operands are unsigned
module mult_datapath import mult_sequencer_pkg::*; #(parameter int DW = DW_DEFAULT) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  input  logic fix,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic count_last,
  output logic sign,
  output logic [2*DW-1:0] result
);
  localparam int DW_2 = 2 * DW;
  localparam int CW = cnt_width(DW);
  logic [DW_2-1:0] mcand;
  logic [DW_2-1:0] acc;
  logic [DW-1:0] mq;
  logic [DW-1:0] mag_a;
  logic [DW-1:0] mag_b;
  logic [CW-1:0] cnt;
`ifdef SIGNED_MODE_EN
  logic neg;
  // the most negative operand maps to 2^(DW-1), still representable unsigned
  assign mag_a = a[DW-1] ? ~a + DW'(ONE) : a;
  assign mag_b = b[DW-1] ? ~b + DW'(ONE) : b;
`else
  assign mag_a = a;
  assign mag_b = b;
`endif
  assign count_last = cnt == CW'(DW - ONE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcand <= '0;
      acc <= '0;
      mq <= '0;
      cnt <= '0;
      result <= '0;
      sign <= 1'b0;
`ifdef SIGNED_MODE_EN
      neg <= 1'b0;
`endif
    end else begin
      if (load) begin
        mcand <= DW_2'(mag_a);
        mq <= mag_b;
        acc <= '0;
        cnt <= CW'(ZERO);
`ifdef SIGNED_MODE_EN
        neg <= a[DW-1] ^ b[DW-1];
`endif
      end else if (step) begin
        acc <= mq[0] ? acc + mcand : acc;
        mcand <= mcand << 1;
        mq <= mq >> 1;
        cnt <= cnt + CW'(ONE);
      end
      if (fix) begin
`ifdef SIGNED_MODE_EN
        result <= neg ? ~acc + DW_2'(ONE) : acc;
        // a zero product is never reported as negative
        sign <= neg & (acc != '0);
`else
        result <= acc;
        sign <= 1'b0;
`endif
      end
    end
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: handshake FSM driving a DW-cycle shift-add multiplier datapath
// ports: clk, rst (async high), io (mult_sequencer_if.slave: start, operands, ready/busy/done/sign/result)
// SIGNED_MODE_EN selects signed operation in mult_datapath; latency is DW+3 either way
module mult_sequencer import mult_sequencer_pkg::*; #(parameter int DW = DW_DEFAULT) (
  input logic clk,
  input logic rst,
  mult_sequencer_if.slave io
);
  state_t state;
  logic load;
  logic step;
  logic fix;
  logic count_last;
  assign load = state == LOAD;
  assign step = state == MULT;
  assign fix = state == FIX;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      io.ready <= BIT_ONE;
      io.busy <= 1'b0;
      io.done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.start) begin
          state <= LOAD;
          io.ready <= 1'b0;
          io.busy <= BIT_ONE;
        end
        LOAD: state <= MULT;
        MULT: if (count_last) state <= FIX;
        FIX: begin
          state <= DONE;
          io.busy <= 1'b0;
          io.done <= BIT_ONE;
        end
        DONE: begin
          state <= IDLE;
          io.done <= 1'b0;
          io.ready <= BIT_ONE;
        end
        default: begin
          state <= IDLE;
          io.ready <= BIT_ONE;
          io.busy <= 1'b0;
          io.done <= 1'b0;
        end
      endcase
    end
  mult_datapath #(.DW(DW)) u_dp (
    .clk(clk),
    .rst(rst),
    .load(load),
    .step(step),
    .fix(fix),
    .a(io.multiplicand),
    .b(io.multiplier),
    .count_last(count_last),
    .sign(io.sign),
    .result(io.result)
  );
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed vector table plus handshake/reset corner sequences for mult_sequencer
module tb_mult_sequencer;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  mult_sequencer_if #(.DW(8)) bus();
  mult_sequencer #(.DW(8)) dut(.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] r;
    logic s;
  } vec_t;
  vec_t v[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic wait_ready(input string nm);
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ready"}, 32'(bus.ready), 1);
  endtask
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r, input logic s, input string nm);
    int n;
    wait_ready(nm);
    bus.multiplicand = a;
    bus.multiplier = b;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    n = 1;
    chk({nm, " busy"}, 32'(bus.busy), 1);
    chk({nm, " not ready"}, 32'(bus.ready), 0);
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, 11);
    chk({nm, " result"}, 32'(bus.result), 32'(r));
    chk({nm, " sign"}, 32'(bus.sign), 32'(s));
    @(negedge clk);
    chk({nm, " done pulse"}, 32'(bus.done), 0);
    chk({nm, " back idle"}, 32'(bus.ready), 1);
    chk({nm, " held"}, 32'(bus.result), 32'(r));
  endtask
  initial begin
    int n;
    int pulses;
    int first;
    int gap_ok;
    int last;
`ifdef SIGNED_MODE_EN
    v[0] = '{8'd7, 8'hFD, 16'hFFEB, 1'b1};
    v[1] = '{8'h80, 8'h80, 16'h4000, 1'b0};
    v[2] = '{8'h80, 8'h7F, 16'hC080, 1'b1};
    v[3] = '{8'hFB, 8'h00, 16'h0000, 1'b0};
    v[4] = '{8'd3, 8'd4, 16'h000C, 1'b0};
    v[5] = '{8'hFF, 8'hFF, 16'h0001, 1'b0};
    v[6] = '{8'h7F, 8'h7F, 16'h3F01, 1'b0};
`else
    v[0] = '{8'd255, 8'd255, 16'hFE01, 1'b0};
    v[1] = '{8'd128, 8'd2, 16'h0100, 1'b0};
    v[2] = '{8'd7, 8'd3, 16'h0015, 1'b0};
    v[3] = '{8'd0, 8'd200, 16'h0000, 1'b0};
    v[4] = '{8'd3, 8'd4, 16'h000C, 1'b0};
    v[5] = '{8'd1, 8'd255, 16'h00FF, 1'b0};
    v[6] = '{8'd170, 8'd85, 16'h3872, 1'b0};
`endif
    bus.start = 0;
    bus.multiplicand = 0;
    bus.multiplier = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset ready", 32'(bus.ready), 1);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset done", 32'(bus.done), 0);
    chk("reset sign", 32'(bus.sign), 0);
    chk("reset result", 32'(bus.result), 0);
    for (int i = 0; i < 7; i++) op(v[i].a, v[i].b, v[i].r, v[i].s, $sformatf("vec%0d", i));
    wait_ready("ignore");
    bus.multiplicand = 8'd7;
    bus.multiplier = 8'd3;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    n = 1;
    while (n < 4) begin
      @(negedge clk);
      n++;
    end
    bus.multiplicand = 8'd255;
    bus.multiplier = 8'd255;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    n++;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ignore latency", n, 11);
    chk("ignore result", 32'(bus.result), 32'h15);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done || !bus.ready) pulses++;
    end
    chk("ignore no requeue", pulses, 0);
    chk("ignore result held", 32'(bus.result), 32'h15);
    bus.multiplicand = 8'd3;
    bus.multiplier = 8'd4;
    bus.start = 1;
    pulses = 0;
    first = 0;
    last = 0;
    gap_ok = 1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 36) bus.start = 0;
      if (bus.done) begin
        pulses++;
        if (first == 0) first = i;
        else if (i - last != 12) gap_ok = 0;
        last = i;
      end
    end
    chk("hold first done", first, 11);
    chk("hold pulses", pulses, 3);
    chk("hold spacing", gap_ok, 1);
    chk("hold result", 32'(bus.result), 32'hC);
    wait_ready("reset");
    bus.multiplicand = 8'd5;
    bus.multiplier = 8'd6;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (4) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async ready", 32'(bus.ready), 1);
    chk("async busy", 32'(bus.busy), 0);
    chk("async done", 32'(bus.done), 0);
    chk("async sign", 32'(bus.sign), 0);
    chk("async result", 32'(bus.result), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post reset ready", 32'(bus.ready), 1);
    op(8'd3, 8'd4, 16'h000C, 1'b0, "fresh");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
